// File: rtl/alu_pkg.sv
// Shared ALU and arbiter types for alu_arbiter, its bench and future ALU clients.
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } arb_state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU: add/sub modulo 2^DATA_W, bitwise and/or; no carry or borrow out.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = '0;
    case (alu_op_t'(mode))
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/rr_picker.sv
// Combinational request picker: round-robin from last_grant+1 by default,
// fixed lowest-index priority when ALU_ARB_FIXED_PRI_EN is defined.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

`ifdef ALU_ARB_FIXED_PRI_EN
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;

  // Descending scan so the lowest-index valid requester is the final write.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant     = '0;
        grant[i]  = 1'b1;
        grant_idx = ID_W'(i);
      end
    end
  end
`else
  always_comb begin
    int  idx;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last_grant) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_idx   = ID_W'(idx);
      end
    end
  end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational alu between NUM_REQ requesters: accept, execute one
// cycle, then hold a tagged response. Picker policy is set by ALU_ARB_FIXED_PRI_EN.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*2-1:0]    req_mode,
  output logic [DATA_W-1:0]       alu_a,
  output logic [DATA_W-1:0]       alu_b,
  output logic [1:0]              alu_mode,
  input  logic [DATA_W-1:0]       alu_result,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [DATA_W-1:0]       rsp_result,
  output logic [1:0]              dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high. Requesters hold valid and operands until ready; ready is one-hot and only
  // raised in IDLE. The response stays valid and stable until rsp_ready is seen.

  arb_state_t             state, state_d;
  logic [ID_W-1:0]        last_grant;
  logic [ID_W-1:0]        cur_id;
  logic [NUM_REQ-1:0]     pick_grant;
  logic [ID_W-1:0]        pick_idx;
  logic                   accept;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (pick_grant),
    .grant_idx  (pick_idx)
  );

  assign accept    = (state == IDLE) && (|req_valid);
  assign req_ready = (state == IDLE) ? pick_grant : '0;
  assign rsp_valid = (state == RESP);
  assign dbg_state = state;

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (|req_valid) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= ID_W'(NUM_REQ - 1);
      cur_id     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_mode   <= '0;
      rsp_id     <= '0;
      rsp_result <= '0;
    end else begin
      if (accept) begin
        alu_a      <= req_a[int'(pick_idx)*DATA_W +: DATA_W];
        alu_b      <= req_b[int'(pick_idx)*DATA_W +: DATA_W];
        alu_mode   <= req_mode[int'(pick_idx)*2 +: 2];
        last_grant <= pick_idx;
        cur_id     <= pick_idx;
      end
      if (state == EXEC) begin
        rsp_result <= alu_result;
        rsp_id     <= cur_id;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with the real alu; follows ALU_ARB_FIXED_PRI_EN.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [7:0]  req_mode;
  logic [3:0]  alu_a;
  logic [3:0]  alu_b;
  logic [1:0]  alu_mode;
  logic [3:0]  alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [3:0]  rsp_result;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  int lat;
  int n;
  logic [5:0] exp_q[$];
  logic [3:0] rr_res[4];
  logic [1:0] eid;

  alu_arbiter #(.NUM_REQ(4), .DATA_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_mode   (req_mode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_mode   (alu_mode),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .dbg_state  (dbg_state)
  );

  alu #(.DATA_W(4)) u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .mode   (alu_mode),
    .result (alu_result)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic set_op(input int id, input logic [3:0] a, input logic [3:0] b,
                        input alu_op_t m);
    req_a[id*4 +: 4]  = a;
    req_b[id*4 +: 4]  = b;
    req_mode[id*2 +: 2] = m;
  endtask

  task automatic wait_grant(input logic [3:0] exp_mask, output int cnt);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cnt++;
      if (req_ready != 4'b0000) break;
    end
    chk("grant", req_ready, exp_mask);
  endtask

  task automatic drop(input int id);
    @(posedge clk);
    #1;
    req_valid[id] = 1'b0;
  endtask

  // scoreboard pop: response owner and result
  task automatic wait_rsp(output int cnt);
    logic [5:0] e;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cnt++;
      if (rsp_valid) break;
    end
    e = exp_q.pop_front();
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_id", rsp_id, e[5:4]);
    chk("rsp_result", rsp_result, e[3:0]);
  endtask

  task automatic do_one(input int id, input logic [3:0] a, input logic [3:0] b,
                        input alu_op_t m, input logic [3:0] res);
    @(posedge clk);
    #1;
    set_op(id, a, b, m);
    req_valid[id] = 1'b1;
    exp_q.push_back({2'(id), res});
    wait_grant(4'(1 << id), n);
    drop(id);
    wait_rsp(lat);
    chk("rsp_latency", lat, 2);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_id"}, rsp_id, 0);
    chk({tag, "_rsp_result"}, rsp_result, 0);
    chk({tag, "_alu_a"}, alu_a, 0);
    chk({tag, "_alu_b"}, alu_b, 0);
    chk({tag, "_alu_mode"}, alu_mode, 0);
    chk({tag, "_state"}, dbg_state, IDLE);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_mode = '0;
    rsp_ready = 1'b1;
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // single request, then wrap-around arithmetic
    do_one(2, 4'ha, 4'h3, ALU_ADD, 4'hd);
    chk("alu_a_hold", alu_a, 4'ha);
    chk("alu_b_hold", alu_b, 4'h3);
    do_one(0, 4'hd, 4'hc, ALU_ADD, 4'h9);
    do_one(1, 4'h2, 4'hb, ALU_SUB, 4'h7);
    chk("alu_mode_hold", alu_mode, ALU_SUB);

    // backpressure: response held 5 cycles, requester 3 waiting
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    set_op(2, 4'h9, 4'h4, ALU_OR);
    req_valid[2] = 1'b1;
    exp_q.push_back({2'd2, 4'hd});
    wait_grant(4'b0100, n);
    drop(2);
    wait_rsp(lat);
    chk("bp_latency", lat, 2);
    set_op(3, 4'h3, 4'h5, ALU_SUB);
    req_valid[3] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_id", rsp_id, 2);
      chk("bp_rsp_result", rsp_result, 4'hd);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_state", dbg_state, RESP);
    end
    rsp_ready = 1'b1;
    exp_q.push_back({2'd3, 4'he});
    wait_grant(4'b1000, n);
    chk("bp_next_grant_delay", n, 1);
    drop(3);
    wait_rsp(lat);
    chk("bp2_latency", lat, 2);

    // all four continuously valid
    rr_res[0] = 4'h9;
    rr_res[1] = 4'h0;
    rr_res[2] = 4'hf;
    rr_res[3] = 4'h2;
    @(posedge clk);
    #1;
    set_op(0, 4'hb, 4'h2, ALU_SUB);
    set_op(1, 4'hc, 4'h3, ALU_AND);
    set_op(2, 4'ha, 4'h5, ALU_OR);
    set_op(3, 4'h1, 4'h1, ALU_ADD);
    req_valid = 4'hf;
    for (int k = 0; k < 5; k++) begin
`ifdef ALU_ARB_FIXED_PRI_EN
      eid = 2'd0;
`else
      eid = 2'(k % 4);
`endif
      exp_q.push_back({eid, rr_res[eid]});
      wait_grant(4'(1 << eid), n);
      wait_rsp(lat);
      chk("rr_latency", lat, 2);
    end
    req_valid = '0;

    // asynchronous reset while a response is held
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    set_op(1, 4'hf, 4'h6, ALU_AND);
    req_valid[1] = 1'b1;
    exp_q.push_back({2'd1, 4'h6});
    wait_grant(4'b0010, n);
    drop(1);
    wait_rsp(lat);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    set_op(0, 4'h7, 4'h8, ALU_ADD);
    req_valid = 4'b0011;
    exp_q.push_back({2'd0, 4'hf});
    wait_grant(4'b0001, n);
    drop(0);
    wait_rsp(lat);
    chk("post_reset_latency", lat, 2);

    // requesters 1 and 3 continuously valid
    set_op(3, 4'h3, 4'h5, ALU_SUB);
    req_valid[3] = 1'b1;
    for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRI_EN
      eid = 2'd1;
`else
      eid = (k % 2 == 0) ? 2'd1 : 2'd3;
`endif
      exp_q.push_back({eid, (eid == 2'd1) ? 4'h6 : 4'he});
      wait_grant(4'(1 << eid), n);
      wait_rsp(lat);
    end
    req_valid = '0;
    repeat (3) @(negedge clk);
    chk("end_idle", dbg_state, IDLE);
    chk("end_queue_empty", exp_q.size(), 0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
